// File: rtl/traffic_light_ctrl_n_pkg.sv
// Shared definitions for the N-approach traffic light sequencer: state encoding,
// lamp bit positions, load_sel codes and reset durations.
package traffic_light_ctrl_n_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_CLEAR  = 3'd3
`ifdef NIGHT_FLASH_EN
        ,
        ST_FLASH  = 3'd4
`endif
    } state_e;

    typedef enum logic [1:0] {
        SEL_GREEN  = 2'd0,
        SEL_YELLOW = 2'd1,
        SEL_CLEAR  = 2'd2,
        SEL_NONE   = 2'd3
    } load_sel_e;

    localparam int LAMP_R = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 0;

    localparam int DEF_GREEN_S  = 30;
    localparam int DEF_YELLOW_S = 3;
    localparam int DEF_CLR_S    = 2;

    localparam int MAX_PHASE   = 4;
    localparam int MAX_SECONDS = 99;

    function automatic logic [2:0] lamp(input logic r, input logic y, input logic g);
        logic [2:0] l;
        l         = '0;
        l[LAMP_R] = r;
        l[LAMP_Y] = y;
        l[LAMP_G] = g;
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_if.sv
// Control/status bundle of the traffic light sequencer; master = board/bench, slave = controller.
interface traffic_light_ctrl_n_if #(
    parameter int N_PHASE = 2,
    parameter int CNT_W   = 7
);
    logic                   start;
    logic                   load;
    logic [1:0]             load_phase;
    logic [1:0]             load_sel;
    logic [CNT_W-1:0]       load_val;
    logic                   advance;
    logic                   up_down;
    logic                   mode;
    logic [3*N_PHASE-1:0]   lamps;
    logic [1:0]             active;
    logic [3:0]             bcd_tens;
    logic [3:0]             bcd_ones;
    logic                   tick;

    modport master (
        output start, load, load_phase, load_sel, load_val, advance, up_down, mode,
        input  lamps, active, bcd_tens, bcd_ones, tick
    );

    modport slave (
        input  start, load, load_phase, load_sel, load_val, advance, up_down, mode,
        output lamps, active, bcd_tens, bcd_ones, tick
    );
endinterface

// File: rtl/traffic_light_ctrl_n_bin2bcd.sv
// Combinational 0..99 binary to two BCD digits for the countdown display.
module bin2bcd_99 (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);
    logic [6:0] sat;

    always_comb begin
        sat    = (bin_i > 7'd99) ? 7'd99 : bin_i;
        tens_o = 4'(sat / 7'd10);
        ones_o = 4'(sat % 7'd10);
    end
endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach GREEN->YELLOW->ALL-RED sequencer with loadable durations and BCD countdown.
// Optional night flash mode is built when NIGHT_FLASH_EN is defined.
module traffic_light_ctrl_n
    import traffic_light_ctrl_n_pkg::*;
#(
    parameter int N_PHASE    = 2,
    parameter int CLK_HZ     = 50_000_000,
    parameter int CNT_W      = 7,
    parameter int DEF_GREEN  = DEF_GREEN_S,
    parameter int DEF_YELLOW = DEF_YELLOW_S,
    parameter int DEF_CLR    = DEF_CLR_S
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    traffic_light_ctrl_n_if.slave bus
);
    localparam int               PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [1:0]       LAST_PH   = 2'(N_PHASE - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAXV      = CNT_W'(MAX_SECONDS);

    state_e                          state_q, state_d;
    logic [1:0]                      active_q, active_d, next_ph;
    logic [CNT_W-1:0]                rem_q, rem_d, dur_q, dur_d;
    logic [PW-1:0]                   presc_q, presc_d;
    logic                            adv_q;
    logic [MAX_PHASE-1:0][CNT_W-1:0] dur_g_q, dur_y_q, dur_c_q;
    logic [3:0]                      tens_q, ones_q, tens_w, ones_w;
    logic                            running_w, timed_w, tick_w, expire, adv_edge, load_en;
    logic [CNT_W-1:0]                load_v, disp_w;
    logic [3*N_PHASE-1:0]            lamps_w;
`ifdef NIGHT_FLASH_EN
    logic                            flash_q, flash_d;
`else
    logic                            unused_mode;
    assign unused_mode = bus.mode;
`endif

    always_comb begin
        running_w = (state_q != ST_IDLE);
        timed_w   = (state_q == ST_GREEN) || (state_q == ST_YELLOW) || (state_q == ST_CLEAR);
        tick_w    = running_w && (presc_q == PRESC_MAX);
        presc_d   = (!running_w || tick_w) ? '0 : presc_q + PW'(1);
        adv_edge  = bus.advance && !adv_q;
        expire    = timed_w && tick_w && (rem_q == ONE);
        next_ph   = (active_q == LAST_PH) ? 2'd0 : active_q + 2'd1;
        load_en   = (state_q == ST_IDLE) && bus.load && (int'(bus.load_phase) < N_PHASE);
        // 0 s would never expire, so it is promoted to the shortest real duration
        if (bus.load_val > MAXV)       load_v = MAXV;
        else if (bus.load_val == '0)   load_v = ONE;
        else                           load_v = bus.load_val;
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rem_d    = rem_q;
        dur_d    = dur_q;
`ifdef NIGHT_FLASH_EN
        flash_d  = flash_q;
`endif
        if (timed_w && tick_w && !expire) rem_d = rem_q - ONE;
        if (!bus.start) begin
            state_d  = ST_IDLE;
            active_d = '0;
            rem_d    = '0;
            dur_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_GREEN;
                    active_d = '0;
                    rem_d    = dur_g_q[0];
                    dur_d    = dur_g_q[0];
`ifdef NIGHT_FLASH_EN
                    if (bus.mode) begin
                        state_d = ST_FLASH;
                        rem_d   = '0;
                        dur_d   = '0;
                        flash_d = 1'b1;
                    end
`endif
                end
                ST_GREEN: if (adv_edge || expire) begin
                    state_d = ST_YELLOW;
                    rem_d   = dur_y_q[active_q];
                    dur_d   = dur_y_q[active_q];
                end
                ST_YELLOW: if (expire) begin
                    state_d = ST_CLEAR;
                    rem_d   = dur_c_q[active_q];
                    dur_d   = dur_c_q[active_q];
                end
                ST_CLEAR: if (expire) begin
`ifdef NIGHT_FLASH_EN
                    if (bus.mode) begin
                        state_d = ST_FLASH;
                        rem_d   = '0;
                        dur_d   = '0;
                        flash_d = 1'b1;
                    end else
`endif
                    begin
                        state_d  = ST_GREEN;
                        active_d = next_ph;
                        rem_d    = dur_g_q[next_ph];
                        dur_d    = dur_g_q[next_ph];
                    end
                end
`ifdef NIGHT_FLASH_EN
                ST_FLASH: begin
                    if (tick_w) flash_d = ~flash_q;
                    // leave through a full clearance of the last phase so phase 0 resumes
                    if (!bus.mode) begin
                        state_d  = ST_CLEAR;
                        active_d = LAST_PH;
                        rem_d    = dur_c_q[LAST_PH];
                        dur_d    = dur_c_q[LAST_PH];
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            rem_q    <= '0;
            dur_q    <= '0;
            presc_q  <= '0;
            adv_q    <= 1'b0;
            tens_q   <= '0;
            ones_q   <= '0;
`ifdef NIGHT_FLASH_EN
            flash_q  <= 1'b0;
`endif
            for (int p = 0; p < MAX_PHASE; p++) begin
                dur_g_q[p] <= CNT_W'(DEF_GREEN);
                dur_y_q[p] <= CNT_W'(DEF_YELLOW);
                dur_c_q[p] <= CNT_W'(DEF_CLR);
            end
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            rem_q    <= rem_d;
            dur_q    <= dur_d;
            presc_q  <= presc_d;
            adv_q    <= bus.advance;
`ifdef NIGHT_FLASH_EN
            flash_q  <= flash_d;
`endif
            if (!bus.start || !timed_w) begin
                tens_q <= '0;
                ones_q <= '0;
            end else begin
                tens_q <= tens_w;
                ones_q <= ones_w;
            end
            if (load_en) begin
                case (load_sel_e'(bus.load_sel))
                    SEL_GREEN:  dur_g_q[bus.load_phase] <= load_v;
                    SEL_YELLOW: dur_y_q[bus.load_phase] <= load_v;
                    SEL_CLEAR:  dur_c_q[bus.load_phase] <= load_v;
                    default:    ;
                endcase
            end
        end
    end

    assign disp_w = bus.up_down ? (dur_q - rem_q) : rem_q;

    bin2bcd_99 u_bcd (
        .bin_i  (7'(disp_w)),
        .tens_o (tens_w),
        .ones_o (ones_w)
    );

    always_comb begin
        for (int p = 0; p < N_PHASE; p++) begin
            lamps_w[3*p +: 3] = lamp(1'b1, 1'b0, 1'b0);
            if (2'(p) == active_q && state_q == ST_GREEN)  lamps_w[3*p +: 3] = lamp(1'b0, 1'b0, 1'b1);
            if (2'(p) == active_q && state_q == ST_YELLOW) lamps_w[3*p +: 3] = lamp(1'b0, 1'b1, 1'b0);
`ifdef NIGHT_FLASH_EN
            if (state_q == ST_FLASH) lamps_w[3*p +: 3] = lamp(1'b0, flash_q, 1'b0);
`endif
        end
    end

    assign bus.lamps    = lamps_w;
    assign bus.active   = active_q;
    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;
    assign bus.tick     = tick_w;

endmodule
